alu_cdb_unit: RTL

- Execution end of the reservation-station issue interface.
- Accepts at most one ready instruction per cycle from the RS (alu_input, arith_type, operands, ROB id).
- Computes the result in a two-stage pipeline and broadcasts it on the CDB as rs_fi / rs_value / rs_rob_id.
- The RS, LSB and ROB consume the broadcast; a ROB clear kills all in-flight work.

---
 rtl/alu_cdb_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_cdb_unit.sv
// ---------------------------------------------------------------------------
// alu_cdb_unit
//
// Purpose:
//   Execution end of the reservation-station issue interface. Takes at most
//   one ready instruction per cycle, computes its result through a two-stage
//   register pipeline and broadcasts it on the common data bus (CDB).
//
// Ports:
//   clk_in       - system clock
//   rst_in       - synchronous, active-high reset
//   rdy_in       - global ready; low freezes every register
//   rob_clear    - flush all in-flight operations
//   alu_input    - valid issue from the RS this cycle
//   arith_type   - operation code (only the low 4 bits are decoded)
//   alu_r1_val   - operand 1
//   alu_r2_val   - operand 2 (register value or immediate)
//   inst_rob_id  - destination ROB id
//   rs_fi        - CDB valid
//   rs_value     - CDB result (holds its last value while rs_fi is low)
//   rs_rob_id    - CDB ROB id (holds its last value while rs_fi is low)
//   alu_busy     - some pipeline stage holds a valid op
// ---------------------------------------------------------------------------
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module alu_cdb_unit #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,
    input  logic                     alu_input,
    input  logic [`RS_TYPE_BIT-1:0]  arith_type,
    input  logic [31:0]              alu_r1_val,
    input  logic [31:0]              alu_r2_val,
    input  logic [`ROB_SIZE_BIT-1:0] inst_rob_id,
    output logic                     rs_fi,
    output logic [31:0]              rs_value,
    output logic [`ROB_SIZE_BIT-1:0] rs_rob_id,
    output logic                     alu_busy
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_BLTU = 4'd14,
        OP_BGEU = 4'd15
    } alu_op_e;

    // Only a depth of two is implemented; the parameter exists so the
    // pipeline depth is visible to integrators. The upper opcode bits carry
    // RS bookkeeping that the ALU does not decode.
    logic unused_inputs;
    assign unused_inputs = (PIPE_DEPTH == 2) ^ (^arith_type[`RS_TYPE_BIT-1:4]);

    // Stage 1 registers: the raw issued instruction.
    logic                     s1_valid;
    alu_op_e                  s1_op;
    logic [31:0]              s1_a;
    logic [31:0]              s1_b;
    logic [`ROB_SIZE_BIT-1:0] s1_rob;

    // Stage 2 registers: the finished result, which is the CDB itself.
    logic                     s2_valid;
    logic [31:0]              s2_value;
    logic [`ROB_SIZE_BIT-1:0] s2_rob;

    logic [31:0] result;
    logic [4:0]  shamt;
    logic        lt_signed;
    logic        lt_unsigned;

    assign shamt       = s1_b[4:0];
    assign lt_signed   = $signed(s1_a) < $signed(s1_b);
    assign lt_unsigned = s1_a < s1_b;

    // Combinational ALU between the stages; compare-style ops produce 0/1.
    always_comb begin
        result = 32'd0;
        case (s1_op)
            OP_ADD:  result = s1_a + s1_b;
            OP_SUB:  result = s1_a - s1_b;
            OP_AND:  result = s1_a & s1_b;
            OP_OR:   result = s1_a | s1_b;
            OP_XOR:  result = s1_a ^ s1_b;
            OP_SLL:  result = s1_a << shamt;
            OP_SRL:  result = s1_a >> shamt;
            OP_SRA:  result = $unsigned($signed(s1_a) >>> shamt);
            OP_SLT:  result = {31'd0, lt_signed};
            OP_SLTU: result = {31'd0, lt_unsigned};
            OP_BEQ:  result = {31'd0, s1_a == s1_b};
            OP_BNE:  result = {31'd0, s1_a != s1_b};
            OP_BLT:  result = {31'd0, lt_signed};
            OP_BGE:  result = {31'd0, ~lt_signed};
            OP_BLTU: result = {31'd0, lt_unsigned};
            OP_BGEU: result = {31'd0, ~lt_unsigned};
            default: result = 32'd0;
        endcase
    end

    // Pipeline registers. Reset wins over everything, rdy_in low freezes
    // all state, and a ROB clear kills both stages including the op being
    // issued in the same cycle. Data registers only load alongside a valid
    // op so the CDB keeps showing the last broadcast while idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= 32'd0;
            s1_b     <= 32'd0;
            s1_rob   <= '0;
            s2_valid <= 1'b0;
            s2_value <= 32'd0;
            s2_rob   <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                s1_valid <= alu_input;
                if (alu_input) begin
                    s1_op  <= alu_op_e'(arith_type[3:0]);
                    s1_a   <= alu_r1_val;
                    s1_b   <= alu_r2_val;
                    s1_rob <= inst_rob_id;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_value <= result;
                    s2_rob   <= s1_rob;
                end
            end
        end
    end

    assign rs_fi     = s2_valid;
    assign rs_value  = s2_value;
    assign rs_rob_id = s2_rob;
    assign alu_busy  = s1_valid | s2_valid;

endmodule
